// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: one byte per cycle through a single registered S-box.
// Define SUB_BYTES_SHIFT_ROWS_EN to fold ShiftRows into the final capture wiring.
module sub_bytes_seq #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t              r_state;
  logic [127:0]        r_src;
  logic [127:0]        r_result;
  logic [3:0]          r_idx;
  logic [3:0]          r_cap_idx;
  logic [SBOX_LAT-1:0] r_pv;
  logic [7:0]          r_sbox [SBOX_LAT];

  logic                w_feed;
  logic                w_cap;
  logic [7:0]          w_sbox_in;
  logic [7:0]          w_sbox_out;
  logic [127:0]        w_sub;
  logic [127:0]        w_final;

  // Byte i lives at bits [127-8i -: 8]; {~i, 3'b111} is that MSB index.
  assign w_feed     = (r_state == FEED);
  assign w_sbox_in  = r_src[{~r_idx, 3'b111} -: 8];
  assign w_sbox_out = r_sbox[SBOX_LAT-1];
  assign w_cap      = r_pv[SBOX_LAT-1];
  assign w_sub      = {r_result[127:8], w_sbox_out};

  // NOTE: the S-box data pipeline is deliberately left without reset; r_pv
  // (which is reset) decides whether its contents are ever captured.
  always_ff @(posedge clk) begin
    r_sbox[0] <= SBOX[{~w_sbox_in, 3'b111} -: 8];
    for (int s = 1; s < SBOX_LAT; s++) r_sbox[s] <= r_sbox[s-1];
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_final = w_sub;
`ifdef SUB_BYTES_SHIFT_ROWS_EN
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w_final[127-8*(r+4*c) -: 8] = w_sub[127-8*(r+4*((c+r)%4)) -: 8];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_state <= '0;
      busy      <= 1'b0;
      r_src     <= '0;
      r_result  <= '0;
      r_idx     <= '0;
      r_cap_idx <= '0;
      r_pv      <= '0;
    end else begin
      r_pv <= (SBOX_LAT)'({r_pv, w_feed});

      if (w_cap) begin
        r_result[{~r_cap_idx, 3'b111} -: 8] <= w_sbox_out;
        r_cap_idx <= r_cap_idx + 4'd1;
      end

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_src     <= in_state;
            r_idx     <= '0;
            r_cap_idx <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            r_state   <= FEED;
          end
        end
        FEED: begin
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd15) r_state <= DRAIN;
        end
        DRAIN: begin
          // out_state is touched only here, so a held result is never disturbed.
          if (w_cap && r_cap_idx == 4'd15) begin
            out_state <= w_final;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            r_state   <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
